// File: rtl/lfsr_application.sv
// Memory-mapped Fibonacci LFSR peripheral: POLY, LFSR seed/state, CTRL mode and
// shift COUNT registers behind a 16-bit address/data/write-strobe port.
module lfsr_application #(
    parameter int n = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         W,
    input  logic [15:0]  A,
    input  logic [n-1:0] D,
    output logic [n-1:0] Q
);

    localparam logic [15:0] ADDR_POLY  = 16'h0010;
    localparam logic [15:0] ADDR_LFSR  = 16'h0012;
    localparam logic [15:0] ADDR_CTRL  = 16'h0014;
    localparam logic [15:0] ADDR_COUNT = 16'h0016;

    typedef enum logic [1:0] {
        MODE_STOP = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    mode_t        mode;
    logic [n-1:0] poly;
    logic [n-1:0] state;
    logic [n-1:0] count;

    logic wr_poly;
    logic wr_lfsr;
    logic wr_ctrl;
    logic shift_en;

    // Tapped bits XOR into the LSB; a zero state or zero polynomial feeds zeros.
    function automatic logic [n-1:0] lfsr_next(input logic [n-1:0] s,
                                               input logic [n-1:0] p);
        return {s[n-2:0], ^(s & p)};
    endfunction

    assign wr_poly  = W && (A == ADDR_POLY);
    assign wr_lfsr  = W && (A == ADDR_LFSR);
    assign wr_ctrl  = W && (A == ADDR_CTRL);
    assign shift_en = (mode == MODE_RUN) || (mode == MODE_STEP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poly  <= '0;
            state <= '0;
            count <= '0;
            mode  <= MODE_STOP;
        end else begin
            if (wr_poly)
                poly <= D;

            // A seed load wins over a shift on the same edge.
            if (wr_lfsr) begin
                state <= D;
                count <= '0;
            end else if (shift_en) begin
                state <= lfsr_next(state, poly);
                count <= count + n'(1);
            end

            // The edge that writes CTRL still runs under the old mode.
            if (wr_ctrl)
                mode <= mode_t'(D[1:0]);
            else if (mode == MODE_STEP)
                mode <= MODE_STOP;
        end
    end

    always_comb begin
        Q = '0;
        case (A)
            ADDR_POLY:  Q = poly;
            ADDR_LFSR:  Q = state;
            ADDR_CTRL:  Q = {{(n-2){1'b0}}, 2'(mode)};
            ADDR_COUNT: Q = count;
            default:    Q = '0;
        endcase
    end

endmodule

// File: tb/tb_lfsr_application.sv
// Scoreboard bench for lfsr_application: stimulus pushes expected read data,
// a monitor pops and compares on the falling edge (or on demand during reset).
`timescale 1ns/1ps
module tb_lfsr_application;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        W = 1'b0;
    logic [15:0] A = 16'h0;
    logic [7:0]  D = 8'h0;
    logic [7:0]  Q;

    lfsr_application #(.n(8)) dut (
        .clock (clock),
        .reset (reset),
        .W     (W),
        .A     (A),
        .D     (D),
        .Q     (Q)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      nm_q[$];
    logic       rd_vld  = 1'b0;
    logic       chk_now = 1'b0;

    // Behavioural model of the register file
    int m_poly, m_state, m_mode, m_count;

    task automatic model_reset();
        m_poly = 0; m_state = 0; m_mode = 0; m_count = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        case (a)
            16'h0010: return 8'(m_poly);
            16'h0012: return 8'(m_state);
            16'h0014: return 8'(m_mode);
            16'h0016: return 8'(m_count);
            default:  return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic w, input logic [15:0] a, input logic [7:0] d);
        bit shifting;
        int fb, nxt;
        shifting = (m_mode == 1) || (m_mode == 2);
        fb  = $countones(m_state & m_poly) % 2;
        nxt = ((m_state * 2) + fb) % 256;
        if (w && a == 16'h0012) begin
            m_state = int'(d);
            m_count = 0;
        end else if (shifting) begin
            m_state = nxt;
            m_count = (m_count + 1) % 256;
        end
        if (w && a == 16'h0010)
            m_poly = int'(d);
        if (w && a == 16'h0014)
            m_mode = int'(d) % 4;
        else if (m_mode == 2)
            m_mode = 0;
    endtask

    // Monitor
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(negedge clock or posedge chk_now);
            if ((rd_vld || chk_now) && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (Q !== e) begin
                    errors++;
                    $display("FAIL %s: A=%h Q=%h expected %h", nm, A, Q, e);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input string nm, input bit use_k, input logic [7:0] k);
        @(posedge clock);
        #1;
        W = w; A = a; D = d;
        exp_q.push_back(use_k ? k : model_read(a));
        nm_q.push_back(nm);
        rd_vld = 1'b1;
        if (reset)
            model_edge(w, a, d);
    endtask

    task automatic cyc(input logic w, input logic [15:0] a, input logic [7:0] d, input string nm);
        issue(w, a, d, nm, 1'b0, 8'h00);
    endtask

    task automatic cyck(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input string nm, input logic [7:0] k);
        issue(w, a, d, nm, 1'b1, k);
    endtask

    // Assert reset between edges and read every register before any clock edge.
    task automatic async_reset();
        logic [15:0] addrs [4];
        addrs = '{16'h0010, 16'h0012, 16'h0014, 16'h0016};
        @(negedge clock);
        #1;
        rd_vld = 1'b0;
        W = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            A = addrs[i];
            exp_q.push_back(8'h00);
            nm_q.push_back("rst_async");
            #1 chk_now = 1'b1;
            #1 chk_now = 1'b0;
        end
    endtask

    task automatic release_reset();
        @(negedge clock);
        #1;
        W = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        int          sel;
        model_reset();

        // Reset held: writes blocked, every register reads 0
        cyck(1, 16'h0010, 8'hFF, "rst_poly", 8'h00);
        cyck(1, 16'h0012, 8'hFF, "rst_lfsr", 8'h00);
        cyck(0, 16'h0014, 8'h00, "rst_ctrl", 8'h00);
        cyck(0, 16'h0016, 8'h00, "rst_count", 8'h00);
        cyck(0, 16'h0010, 8'h00, "rst_poly2", 8'h00);
        release_reset();

        // Config
        cyc(1, 16'h0010, 8'hDD, "cfg_wp");
        cyc(1, 16'h0012, 8'h78, "cfg_wl");
        cyc(1, 16'h0014, 8'h00, "cfg_wc");
        for (int i = 0; i < 5; i++) cyc(0, 16'h0012, 8'h00, "cfg_idle");
        cyck(0, 16'h0012, 8'h00, "cfg_lfsr", 8'h78);
        cyck(0, 16'h0016, 8'h00, "cfg_count", 8'h00);
        cyck(0, 16'h0010, 8'h00, "cfg_poly", 8'hDD);
        cyck(0, 16'h0014, 8'h00, "cfg_ctrl", 8'h00);

        // STEP
        cyck(1, 16'h0014, 8'h02, "step_wr", 8'h00);
        cyck(0, 16'h0012, 8'h00, "step_pre", 8'h78);
        cyck(0, 16'h0012, 8'h00, "step_lfsr", 8'hF1);
        cyck(0, 16'h0016, 8'h00, "step_count", 8'h01);
        cyck(0, 16'h0014, 8'h00, "step_ctrl", 8'h00);
        cyck(0, 16'h0012, 8'h00, "step_hold", 8'hF1);

        // RUN
        cyc(1, 16'h0012, 8'h78, "run_seed");
        cyc(1, 16'h0014, 8'h01, "run_wr");
        cyck(0, 16'h0012, 8'h00, "run_s0", 8'h78);
        cyck(0, 16'h0012, 8'h00, "run_s1", 8'hF1);
        cyck(0, 16'h0012, 8'h00, "run_s2", 8'hE2);
        cyck(0, 16'h0016, 8'h00, "run_count", 8'h03);
        cyck(1, 16'h0014, 8'h00, "run_ctrl", 8'h01);
        cyck(0, 16'h0012, 8'h00, "run_last", 8'h13);
        cyck(0, 16'h0012, 8'h00, "stop_hold", 8'h13);
        cyck(0, 16'h0016, 8'h00, "stop_count", 8'h05);

        // Seed during RUN
        cyc(1, 16'h0014, 8'h01, "seed_run");
        cyck(1, 16'h0012, 8'h55, "seed_wr", 8'h13);
        cyck(0, 16'h0016, 8'h00, "seed_count", 8'h00);
        cyck(0, 16'h0012, 8'h00, "seed_shift", 8'hAA);
        cyck(0, 16'h0016, 8'h00, "seed_count2", 8'h02);

        // Unmapped write and read
        cyck(1, 16'h0020, 8'hFF, "unmapped", 8'h00);
        cyck(0, 16'h0020, 8'h00, "unmapped2", 8'h00);
        cyc(0, 16'h0010, 8'h00, "unmapped_poly");

        // Reset mid-run
        async_reset();
        cyck(1, 16'h0014, 8'h01, "rsthold_ctrl", 8'h00);
        release_reset();
        cyck(0, 16'h0014, 8'h00, "post_rst_ctrl", 8'h00);
        cyck(0, 16'h0012, 8'h00, "post_rst_lfsr", 8'h00);
        cyck(0, 16'h0016, 8'h00, "post_rst_count", 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 6);
            if (sel < 4)       a = 16'h0010 + 16'(2 * sel);
            else if (sel == 4) a = 16'h0011;
            else if (sel == 5) a = 16'h0020;
            else               a = 16'($urandom);
            w = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            cyc(w, a, d, "rand");
            if (i == 300) begin
                async_reset();
                release_reset();
            end
        end

        @(negedge clock);
        #1;
        rd_vld = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
